// File: rtl/axis_chk_pkg.sv
// Shared definitions for the AXI-Stream RX traffic checker.
// Contents:
//   - frame classification codes (ERR_*)
//   - receive FSM state type
//   - statistics counter width
//   - popcount8 / keep_last_legal helpers used by the beat checks
package axis_chk_pkg;

  localparam int CNT_W = 32;

  localparam logic [2:0] ERR_GOOD  = 3'd0;
  localparam logic [2:0] ERR_TUSER = 3'd1;
  localparam logic [2:0] ERR_LEN   = 3'd2;
  localparam logic [2:0] ERR_KEEP  = 3'd3;
  localparam logic [2:0] ERR_PAT   = 3'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DROP = 2'd2
  } state_t;

  // Number of set bits in a byte-enable vector.
  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] c;
    c = 4'd0;
    for (int i = 0; i < 8; i++) begin
      c = c + {3'd0, v[i]};
    end
    return c;
  endfunction

  // A last beat must carry a contiguous run of bytes starting at byte 0.
  function automatic logic keep_last_legal(input logic [7:0] k);
    logic ok;
    case (k)
      8'h01, 8'h03, 8'h07, 8'h0F,
      8'h1F, 8'h3F, 8'h7F, 8'hFF: ok = 1'b1;
      default:                    ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/axis_rx_check_module_sat_cnt.sv
// Saturating statistics counter.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear, wins over inc
//   inc        : count one event
//   cnt        : current count, sticks at all-ones
module sat_cnt32_module
  import axis_chk_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_r;

  // Counter register: clear has priority, increment stops at full scale.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (clr) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (inc && (cnt_r != {CNT_W{1'b1}})) begin
      cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt = cnt_r;

endmodule

// File: rtl/axis_rx_check_module.sv
// Receive-side traffic checker for one 10G Ethernet channel.
// Consumes the MAC RX AXI-Stream (no backpressure), checks each frame
// for length window, tkeep legality, MAC bad-frame flag and payload
// pattern, reports one classification per frame and keeps saturating
// per-class statistics.
// Ports:
//   i_clk, i_rst_n     : MAC RX clock, asynchronous active-low reset
//   i_stat_rx_status   : link-up status; frames seen while down are dropped
//   i_clr_cnt          : synchronous clear of all statistics
//   s_axis_rx_*        : RX stream (tvalid/tdata/tlast/tkeep/tuser)
//   o_frame_done       : one-cycle pulse per classified frame
//   o_frame_ok/o_err_code/o_frame_len : result of the last classified frame
//   o_*_cnt            : per-class frame counters
module axis_rx_check_module
  import axis_chk_pkg::*;
#(
  parameter logic [7:0]  P_MIN_LENGTH = 8'd64,
  parameter logic [14:0] P_MAX_LENGTH = 15'd9600,
  parameter int          P_HDR_BEATS  = 2
)(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_stat_rx_status,
  input  logic        i_clr_cnt,
  input  logic        s_axis_rx_tvalid,
  input  logic [63:0] s_axis_rx_tdata,
  input  logic        s_axis_rx_tlast,
  input  logic [7:0]  s_axis_rx_tkeep,
  input  logic        s_axis_rx_tuser,
  output logic        o_frame_done,
  output logic        o_frame_ok,
  output logic [2:0]  o_err_code,
  output logic [14:0] o_frame_len,
  output logic [31:0] o_good_cnt,
  output logic [31:0] o_tuser_cnt,
  output logic [31:0] o_len_cnt,
  output logic [31:0] o_keep_cnt,
  output logic [31:0] o_pat_cnt
);

  localparam logic [14:0] HDR_K   = 15'(P_HDR_BEATS);
  localparam logic [14:0] K_MAX   = 15'h7FFF;

  state_t      state_r;
  logic [14:0] beat_idx_r;   // index of the next beat while in RECV
  logic        keep_err_r;
  logic        pat_err_r;
  logic        frame_done_r;
  logic        frame_ok_r;
  logic [2:0]  err_code_r;
  logic [14:0] frame_len_r;

  logic [14:0] cur_k_s;
  logic [14:0] next_k_s;
  logic        keep_now_s;
  logic        pat_now_s;
  logic        keep_any_s;
  logic        pat_any_s;
  logic [18:0] len_wide_s;
  logic [14:0] len_sat_s;
  logic        len_err_s;
  logic [2:0]  err_s;
  logic        classify_s;

  // Per-beat checks and the classification that would apply if this beat ends the frame.
  always_comb begin
    // The first beat of a frame is always taken in IDLE, so its index is 0
    // and the sticky flags from any earlier frame are ignored there.
    if (state_r == IDLE) begin
      cur_k_s    = 15'd0;
      keep_any_s = 1'b0;
      pat_any_s  = 1'b0;
    end else begin
      cur_k_s    = beat_idx_r;
      keep_any_s = keep_err_r;
      pat_any_s  = pat_err_r;
    end

    if (cur_k_s == K_MAX) begin
      next_k_s = cur_k_s;
    end else begin
      next_k_s = cur_k_s + 15'd1;
    end

    if (s_axis_rx_tlast) begin
      keep_now_s = ~keep_last_legal(s_axis_rx_tkeep);
    end else begin
      keep_now_s = (s_axis_rx_tkeep != 8'hFF);
    end

    pat_now_s = 1'b0;
    if (cur_k_s >= HDR_K) begin
      for (int i = 0; i < 8; i++) begin
        if (s_axis_rx_tkeep[i] && (s_axis_rx_tdata[8*i +: 8] != cur_k_s[7:0])) begin
          pat_now_s = 1'b1;
        end else begin
          pat_now_s = pat_now_s;
        end
      end
    end else begin
      pat_now_s = 1'b0;
    end

    keep_any_s = keep_any_s | keep_now_s;
    pat_any_s  = pat_any_s  | pat_now_s;

    // 8*(beats-1) + bytes on the last beat, widened so overflow is visible.
    len_wide_s = {1'b0, cur_k_s, 3'b000} + {15'd0, popcount8(s_axis_rx_tkeep)};
    if (len_wide_s > 19'd32767) begin
      len_sat_s = 15'h7FFF;
      len_err_s = 1'b1;
    end else begin
      len_sat_s = len_wide_s[14:0];
      len_err_s = (len_sat_s < {7'd0, P_MIN_LENGTH}) || (len_sat_s > P_MAX_LENGTH);
    end

    if (s_axis_rx_tuser) begin
      err_s = ERR_TUSER;
    end else if (len_err_s) begin
      err_s = ERR_LEN;
    end else if (keep_any_s) begin
      err_s = ERR_KEEP;
    end else if (pat_any_s) begin
      err_s = ERR_PAT;
    end else begin
      err_s = ERR_GOOD;
    end

    classify_s = s_axis_rx_tvalid && s_axis_rx_tlast && i_stat_rx_status &&
                 ((state_r == IDLE) || (state_r == RECV));
  end

  // Receive FSM with registered classification outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r      <= IDLE;
      beat_idx_r   <= 15'd0;
      keep_err_r   <= 1'b0;
      pat_err_r    <= 1'b0;
      frame_done_r <= 1'b0;
      frame_ok_r   <= 1'b0;
      err_code_r   <= 3'd0;
      frame_len_r  <= 15'd0;
    end else begin
      frame_done_r <= 1'b0;
      if (classify_s) begin
        frame_done_r <= 1'b1;
        frame_ok_r   <= (err_s == ERR_GOOD);
        err_code_r   <= err_s;
        frame_len_r  <= len_sat_s;
      end
      case (state_r)
        IDLE: begin
          if (s_axis_rx_tvalid && !s_axis_rx_tlast) begin
            if (i_stat_rx_status) begin
              state_r    <= RECV;
              beat_idx_r <= next_k_s;
              keep_err_r <= keep_now_s;
              pat_err_r  <= pat_now_s;
            end else begin
              state_r <= DROP;
            end
          end
        end
        RECV: begin
          if (!i_stat_rx_status) begin
            // A frame that loses link is abandoned; if its last beat is
            // already here there is nothing further to discard.
            state_r <= (s_axis_rx_tvalid && s_axis_rx_tlast) ? IDLE : DROP;
          end else if (s_axis_rx_tvalid) begin
            if (s_axis_rx_tlast) begin
              state_r <= IDLE;
            end else begin
              beat_idx_r <= next_k_s;
              keep_err_r <= keep_any_s;
              pat_err_r  <= pat_any_s;
            end
          end
        end
        DROP: begin
          if (s_axis_rx_tvalid && s_axis_rx_tlast) begin
            state_r <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  sat_cnt32_module u_good_cnt (
    .clk(i_clk), .rst_n(i_rst_n), .clr(i_clr_cnt),
    .inc(classify_s && (err_s == ERR_GOOD)), .cnt(o_good_cnt));
  sat_cnt32_module u_tuser_cnt (
    .clk(i_clk), .rst_n(i_rst_n), .clr(i_clr_cnt),
    .inc(classify_s && (err_s == ERR_TUSER)), .cnt(o_tuser_cnt));
  sat_cnt32_module u_len_cnt (
    .clk(i_clk), .rst_n(i_rst_n), .clr(i_clr_cnt),
    .inc(classify_s && (err_s == ERR_LEN)), .cnt(o_len_cnt));
  sat_cnt32_module u_keep_cnt (
    .clk(i_clk), .rst_n(i_rst_n), .clr(i_clr_cnt),
    .inc(classify_s && (err_s == ERR_KEEP)), .cnt(o_keep_cnt));
  sat_cnt32_module u_pat_cnt (
    .clk(i_clk), .rst_n(i_rst_n), .clr(i_clr_cnt),
    .inc(classify_s && (err_s == ERR_PAT)), .cnt(o_pat_cnt));

  assign o_frame_done = frame_done_r;
  assign o_frame_ok   = frame_ok_r;
  assign o_err_code   = err_code_r;
  assign o_frame_len  = frame_len_r;

endmodule

// File: tb/tb_axis_rx_check_module.sv
// Scoreboard bench for axis_rx_check_module: frames are described as
// beat arrays, a reference model derives the expected class, length and
// counter values, and a monitor compares them on every o_frame_done.
module tb_axis_rx_check_module;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        status;
  logic        clr_cnt;
  logic        tvalid;
  logic [63:0] tdata;
  logic        tlast;
  logic [7:0]  tkeep;
  logic        tuser;
  logic        frame_done;
  logic        frame_ok;
  logic [2:0]  err_code;
  logic [14:0] frame_len;
  logic [31:0] good_cnt, tuser_cnt, len_cnt, keep_cnt, pat_cnt;

  axis_rx_check_module dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_stat_rx_status(status), .i_clr_cnt(clr_cnt),
    .s_axis_rx_tvalid(tvalid), .s_axis_rx_tdata(tdata), .s_axis_rx_tlast(tlast),
    .s_axis_rx_tkeep(tkeep), .s_axis_rx_tuser(tuser),
    .o_frame_done(frame_done), .o_frame_ok(frame_ok), .o_err_code(err_code),
    .o_frame_len(frame_len), .o_good_cnt(good_cnt), .o_tuser_cnt(tuser_cnt),
    .o_len_cnt(len_cnt), .o_keep_cnt(keep_cnt), .o_pat_cnt(pat_cnt));

  always #5 clk = ~clk;

  typedef struct packed {
    logic             ok;
    logic [2:0]       code;
    logic [14:0]      len;
    logic [4:0][31:0] cnt;   // index = class code
  } exp_t;

  exp_t        sb[$];
  logic [63:0] fdata[$];
  logic [7:0]  fkeep[$];
  logic [4:0][31:0] mcnt;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int ones8(input logic [7:0] v);
    int c = 0;
    for (int i = 0; i < 8; i++) if (v[i]) c++;
    return c;
  endfunction

  // Reference model: classify the frame held in fdata/fkeep.
  task automatic model_frame(input logic usr, input logic clr, output exp_t e);
    int n, lenw, len, code;
    bit lerr, kerr, perr;
    logic [8:0] lk;
    n = fdata.size();
    lenw = 8 * (n - 1) + ones8(fkeep[n-1]);
    len  = (lenw > 32767) ? 32767 : lenw;
    lerr = (lenw > 32767) || (len < 64) || (len > 9600);
    kerr = 1'b0;
    for (int k = 0; k < n - 1; k++) if (fkeep[k] != 8'hFF) kerr = 1'b1;
    lk = {1'b0, fkeep[n-1]};
    if ((lk == 9'd0) || ((lk & (lk + 9'd1)) != 9'd0)) kerr = 1'b1;
    perr = 1'b0;
    for (int k = 2; k < n; k++)
      for (int b = 0; b < 8; b++)
        if (fkeep[k][b] && (fdata[k][8*b +: 8] != 8'(k % 256))) perr = 1'b1;
    code = usr ? 1 : lerr ? 2 : kerr ? 3 : perr ? 4 : 0;
    if (clr) mcnt = '0;
    else if (mcnt[code] != 32'hFFFF_FFFF) mcnt[code] = mcnt[code] + 32'd1;
    e.ok   = (code == 0);
    e.code = 3'(code);
    e.len  = 15'(len);
    e.cnt  = mcnt;
  endtask

  // Correct-pattern frame of n beats; header beats carry random bytes.
  task automatic build_good(input int n, input logic [7:0] last_keep);
    fdata.delete();
    fkeep.delete();
    for (int k = 0; k < n; k++) begin
      if (k >= 2) fdata.push_back({8{k[7:0]}});
      else        fdata.push_back({$urandom, $urandom});
      fkeep.push_back((k == n - 1) ? last_keep : 8'hFF);
    end
  endtask

  task automatic idle(input int n);
    tvalid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic put_beat(input logic [63:0] d, input logic [7:0] kp, input logic lst,
                          input logic usr, input logic clr);
    tvalid = 1'b1; tdata = d; tkeep = kp; tlast = lst; tuser = usr; clr_cnt = clr;
    @(posedge clk); #1;
    tvalid = 1'b0; tlast = 1'b0; tuser = 1'b0; clr_cnt = 1'b0;
  endtask

  // drop_at >= 0: link goes down at that beat, so no result is expected.
  task automatic drive_frame(input logic usr, input logic clr_last, input int drop_at, input bit gaps);
    int n;
    exp_t e;
    n = fdata.size();
    if (drop_at < 0) begin
      model_frame(usr, clr_last, e);
      sb.push_back(e);
    end
    for (int k = 0; k < n; k++) begin
      if (gaps && ($urandom_range(3, 0) == 0)) idle($urandom_range(2, 1));
      if (k == drop_at) status = 1'b0;
      put_beat(fdata[k], fkeep[k], (k == n - 1), (k == n - 1) ? usr : 1'b0,
               (k == n - 1) ? clr_last : 1'b0);
    end
    if (drop_at >= 0) begin
      idle(1);
      status = 1'b1;
    end
  endtask

  // Monitor: every o_frame_done must match the oldest expected result.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && frame_done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("frame_ok",  {31'd0, frame_ok}, {31'd0, e.ok});
        chk("err_code",  {29'd0, err_code}, {29'd0, e.code});
        chk("frame_len", {17'd0, frame_len}, {17'd0, e.len});
        chk("good_cnt",  good_cnt,  e.cnt[0]);
        chk("tuser_cnt", tuser_cnt, e.cnt[1]);
        chk("len_cnt",   len_cnt,   e.cnt[2]);
        chk("keep_cnt",  keep_cnt,  e.cnt[3]);
        chk("pat_cnt",   pat_cnt,   e.cnt[4]);
      end
    end
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_done"}, {31'd0, frame_done}, 32'd0);
    chk({tag, "_ok"},   {31'd0, frame_ok}, 32'd0);
    chk({tag, "_code"}, {29'd0, err_code}, 32'd0);
    chk({tag, "_len"},  {17'd0, frame_len}, 32'd0);
    chk({tag, "_good"}, good_cnt, 32'd0);
    chk({tag, "_tusr"}, tuser_cnt, 32'd0);
    chk({tag, "_lenc"}, len_cnt, 32'd0);
    chk({tag, "_keep"}, keep_cnt, 32'd0);
    chk({tag, "_pat"},  pat_cnt, 32'd0);
  endtask

  logic [63:0] tmp;
  int n, kk, bb, wait_cyc;
  logic [7:0] lk;

  initial begin
    rst_n = 1'b0; status = 1'b1; clr_cnt = 1'b0;
    tvalid = 1'b0; tdata = 64'd0; tlast = 1'b0; tkeep = 8'd0; tuser = 1'b0;
    mcnt = '0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    idle(2);

    // Good 64-byte frame, then a short 60-byte frame and a 9601-byte one.
    build_good(8, 8'hFF);    drive_frame(1'b0, 1'b0, -1, 1'b0);
    build_good(8, 8'h0F);    drive_frame(1'b0, 1'b0, -1, 1'b0);
    build_good(1201, 8'h01); drive_frame(1'b0, 1'b0, -1, 1'b0);

    // Pattern corruption, then the same frame with tuser to check priority.
    build_good(8, 8'hFF);
    tmp = fdata[3]; tmp[47:40] = 8'hAA; fdata[3] = tmp;
    drive_frame(1'b0, 1'b0, -1, 1'b0);
    drive_frame(1'b1, 1'b0, -1, 1'b0);

    // Keep error in the middle, immediately followed by a good frame.
    build_good(8, 8'hFF); fkeep[2] = 8'h0F;
    drive_frame(1'b0, 1'b0, -1, 1'b0);
    build_good(8, 8'hFF);
    drive_frame(1'b0, 1'b0, -1, 1'b0);

    // Link drop at beat 4, then a good frame.
    build_good(8, 8'hFF); drive_frame(1'b0, 1'b0, 4, 1'b0);
    build_good(9, 8'h03); drive_frame(1'b0, 1'b0, -1, 1'b0);

    // Single-beat frame and a frame long enough to saturate the length.
    build_good(1, 8'hFF);    drive_frame(1'b0, 1'b0, -1, 1'b0);
    build_good(4200, 8'hFF); drive_frame(1'b0, 1'b0, -1, 1'b0);

    // Randomised traffic with gaps, errors and occasional link drops.
    for (int f = 0; f < 40; f++) begin
      n  = ($urandom_range(7, 0) == 0) ? $urandom_range(7, 1) : $urandom_range(24, 8);
      lk = ($urandom_range(5, 0) == 0) ? 8'($urandom) : (8'hFF >> $urandom_range(7, 0));
      build_good(n, lk);
      if ((n > 1) && ($urandom_range(7, 0) == 0)) fkeep[$urandom_range(n - 2, 0)] = 8'($urandom);
      if ($urandom_range(5, 0) == 0) begin
        kk = $urandom_range(n - 1, 0); bb = $urandom_range(7, 0);
        tmp = fdata[kk]; tmp[8*bb +: 8] = tmp[8*bb +: 8] ^ 8'($urandom_range(255, 1)); fdata[kk] = tmp;
      end
      if ((n >= 3) && ($urandom_range(7, 0) == 0))
        drive_frame(1'b0, 1'b0, $urandom_range(n - 2, 0), 1'b1);
      else
        drive_frame(($urandom_range(7, 0) == 0), 1'b0, -1, 1'b1);
    end

    // Clear coincident with a good frame's last beat: the clear wins.
    build_good(8, 8'hFF); drive_frame(1'b0, 1'b1, -1, 1'b0);
    build_good(8, 8'hFF); drive_frame(1'b0, 1'b0, -1, 1'b0);
    build_good(8, 8'h3F); drive_frame(1'b0, 1'b0, -1, 1'b0);
    idle(3);

    // Asynchronous reset in the middle of a frame.
    build_good(8, 8'hFF);
    for (int k = 0; k < 3; k++) put_beat(fdata[k], fkeep[k], 1'b0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_rst");
    sb.delete();
    mcnt = '0;
    @(posedge clk); #3 rst_n = 1'b1;
    idle(1);
    build_good(8, 8'hFF); drive_frame(1'b0, 1'b0, -1, 1'b0);

    wait_cyc = 0;
    while ((sb.size() != 0) && (wait_cyc < 100)) begin
      @(posedge clk);
      wait_cyc++;
    end
    #1;
    chk("scoreboard_drained", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
